// File: rtl/pred_pkg.sv
// Shared predictor package: 2-bit counter encodings, counter reset value,
// target-buffer entry layout and the default widths that the gshare
// predictor and the tournament selector agree on.
package pred_pkg;

  // Default widths shared with the tournament selector.
  localparam int PC_W_DEF     = 32;
  localparam int GH_BITS_DEF  = 8;
  localparam int BTB_BITS_DEF = 4;

  // 2-bit direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,  // strong not-taken
    WNT = 2'b01,  // weak not-taken
    WT  = 2'b10,  // weak taken
    ST  = 2'b11   // strong taken
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;

  // Direct-mapped target buffer entry; the tag is the full PC.
  typedef struct packed {
    logic                valid;
    logic [PC_W_DEF-1:0] tag;
    logic [PC_W_DEF-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, next-state only (no storage).
// Ports:
//   ctr      in  2  current counter value
//   inc      in  1  1 = count up toward ST, 0 = count down toward SNT
//   ctr_next out 2  saturated next value
module sat_counter2
  import pred_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] ctr_next
);

  // Saturating step: ST stays ST on increment, SNT stays SNT on decrement.
  always_comb begin
    ctr_next = ctr;
    case (ctr)
      SNT:     ctr_next = inc ? WNT : SNT;
      WNT:     ctr_next = inc ? WT  : SNT;
      WT:      ctr_next = inc ? ST  : WNT;
      ST:      ctr_next = inc ? ST  : WT;
      default: ctr_next = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor with a small direct-mapped target buffer.
// The PHT is indexed by PC xor global history; the history register is
// non-speculative and only shifts on resolved branches. Lookups see the
// state as it was before the current edge (read-before-write, no bypass).
// Ports:
//   clock          in   1     rising-edge clock
//   reset          in   1     asynchronous active-low reset
//   PC             in   PC_W  lookup PC
//   lookup_valid   in   1     PC is a valid lookup this cycle
//   fix_valid      in   1     resolved-branch update this cycle
//   fix_PC         in   PC_W  PC of the resolved branch
//   fix_result     in   1     actual outcome, 1 = taken
//   fix_target     in   PC_W  actual taken target
//   prediction_gh  out  1     predicted direction (registered)
//   gh_PC          out  PC_W  predicted next PC (registered)
//   pred_valid     out  1     lookup_valid delayed one cycle
module gshare_predictor
  import pred_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int GH_BITS  = GH_BITS_DEF,
  parameter int BTB_BITS = BTB_BITS_DEF
)(
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] PC,
  input  logic            lookup_valid,
  input  logic            fix_valid,
  input  logic [PC_W-1:0] fix_PC,
  input  logic            fix_result,
  input  logic [PC_W-1:0] fix_target,
  output logic            prediction_gh,
  output logic [PC_W-1:0] gh_PC,
  output logic            pred_valid
);

  localparam int PHT_N = 2 ** GH_BITS;
  localparam int BTB_N = 2 ** BTB_BITS;
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [GH_BITS-1:0] ghr_r;
  logic [1:0]         pht_r [PHT_N];
  btb_entry_t         btb_r [BTB_N];

  logic [GH_BITS-1:0] li_s;
  logic [GH_BITS-1:0] ui_s;
  logic [1:0]         ctr_rd_s;
  logic [1:0]         ctr_upd_s;
  logic [1:0]         ctr_next_s;
  btb_entry_t         btb_rd_s;
  logic               taken_s;
  logic               hit_s;
  logic [PC_W-1:0]    next_pc_s;

  // Lookup path: PHT and BTB reads, next-PC selection (wraps modulo 2**PC_W).
  always_comb begin
    li_s      = PC[GH_BITS-1:0] ^ ghr_r;
    ctr_rd_s  = pht_r[li_s];
    taken_s   = ctr_rd_s[1];
    btb_rd_s  = btb_r[PC[BTB_BITS-1:0]];
    hit_s     = btb_rd_s.valid && (btb_rd_s.tag == PC);
    if (taken_s && hit_s) begin
      next_pc_s = btb_rd_s.target;
    end else begin
      next_pc_s = PC + PC_ONE;
    end
  end

  // Update index uses the history as it stands before this edge.
  always_comb begin
    ui_s      = fix_PC[GH_BITS-1:0] ^ ghr_r;
    ctr_upd_s = pht_r[ui_s];
  end

  sat_counter2 u_sat_counter2 (
    .ctr      (ctr_upd_s),
    .inc      (fix_result),
    .ctr_next (ctr_next_s)
  );

  // Registered prediction outputs; direction/target hold when no lookup.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pred_valid    <= 1'b0;
      prediction_gh <= 1'b0;
      gh_PC         <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        prediction_gh <= taken_s;
        gh_PC         <= next_pc_s;
      end
    end
  end

  // Global history: shifts in the resolved outcome only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ghr_r <= '0;
    end else if (fix_valid) begin
      ghr_r <= {ghr_r[GH_BITS-2:0], fix_result};
    end
  end

  // Pattern history table of saturating counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht_r[i] <= CTR_RESET;
      end
    end else if (fix_valid) begin
      pht_r[ui_s] <= ctr_next_s;
    end
  end

  // Target buffer: allocated/overwritten by taken branches only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_r[i] <= '0;
      end
    end else if (fix_valid && fix_result) begin
      btb_r[fix_PC[BTB_BITS-1:0]] <= '{valid: 1'b1, tag: fix_PC, target: fix_target};
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  logic        clock;
  logic        reset;
  logic [31:0] PC;
  logic        lookup_valid;
  logic        fix_valid;
  logic [31:0] fix_PC;
  logic        fix_result;
  logic [31:0] fix_target;
  logic        prediction_gh;
  logic [31:0] gh_PC;
  logic        pred_valid;

  int passed;
  int checks;
  logic [33:0] obs;
  logic [33:0] exp;

  gshare_predictor dut (
    .clock         (clock),
    .reset         (reset),
    .PC            (PC),
    .lookup_valid  (lookup_valid),
    .fix_valid     (fix_valid),
    .fix_PC        (fix_PC),
    .fix_result    (fix_result),
    .fix_target    (fix_target),
    .prediction_gh (prediction_gh),
    .gh_PC         (gh_PC),
    .pred_valid    (pred_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    lookup_valid = 1'b0;
    fix_valid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic do_fix(input logic [31:0] pc, input logic res, input logic [31:0] tgt);
    fix_valid  = 1'b1;
    fix_PC     = pc;
    fix_result = res;
    fix_target = tgt;
    step();
    fix_valid  = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    PC = pc;
    lookup_valid = 1'b1;
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    exp = {1'b0, 1'b0, 32'd0};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL reset_hold actual=%h required=%h", obs, exp);
    else passed++;
    reset = 1'b1;
    step();
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL reset_release actual=%h required=%h", obs, exp);
    else passed++;
    do_lookup(32'd5);
    exp = {1'b1, 1'b0, 32'd6};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL reset_first_lookup actual=%h required=%h", obs, exp);
    else passed++;
    step();
    exp = {1'b0, 1'b0, 32'd6};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL reset_hold_outputs actual=%h required=%h", obs, exp);
    else passed++;
  endtask

  task automatic test_saturation();
    apply_reset();
    // Each taken fix is followed by 8 not-taken fixes elsewhere so GHR is 0 again.
    for (int r = 0; r < 4; r++) begin
      do_fix(32'd3, 1'b1, 32'd40);
      for (int k = 0; k < 8; k++) do_fix(32'd100, 1'b0, 32'd0);
    end
    do_lookup(32'd3);
    exp = {1'b1, 1'b1, 32'd40};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL sat_top actual=%h required=%h", obs, exp);
    else passed++;
    // Not-taken fixes keep GHR at 0, so index 3 is hit every time.
    do_fix(32'd3, 1'b0, 32'd0);
    do_lookup(32'd3);
    exp = {1'b1, 1'b1, 32'd40};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL sat_weak_taken actual=%h required=%h", obs, exp);
    else passed++;
    for (int k = 0; k < 3; k++) do_fix(32'd3, 1'b0, 32'd0);
    do_lookup(32'd3);
    exp = {1'b1, 1'b0, 32'd4};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL sat_bottom actual=%h required=%h", obs, exp);
    else passed++;
    do_fix(32'd3, 1'b1, 32'd40);
    do_lookup(32'd2);
    exp = {1'b1, 1'b0, 32'd3};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL sat_recover actual=%h required=%h", obs, exp);
    else passed++;
  endtask

  task automatic test_aliasing();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      do_fix(32'd0, 1'b1, 32'd50);
      do_fix(32'd1, 1'b0, 32'd0);
    end
    // GHR is now 8'hAA; counter 170 = ST, 84 = SNT, 2 = WT, 0 = WNT.
    do_lookup(32'd0);
    exp = {1'b1, 1'b1, 32'd50};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL alias_pc0 actual=%h required=%h", obs, exp);
    else passed++;
    do_lookup(32'h100);
    exp = {1'b1, 1'b1, 32'h101};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL alias_pc100 actual=%h required=%h", obs, exp);
    else passed++;
    do_lookup(32'hA8);
    exp = {1'b1, 1'b1, 32'hA9};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL alias_idx2 actual=%h required=%h", obs, exp);
    else passed++;
    do_lookup(32'hFE);
    exp = {1'b1, 1'b0, 32'hFF};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL alias_idx84 actual=%h required=%h", obs, exp);
    else passed++;
    do_lookup(32'd1);
    exp = {1'b1, 1'b0, 32'd2};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL alias_pc1 actual=%h required=%h", obs, exp);
    else passed++;
    do_lookup(32'hAA);
    exp = {1'b1, 1'b0, 32'hAB};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL alias_idx0 actual=%h required=%h", obs, exp);
    else passed++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    PC = 32'd7;
    lookup_valid = 1'b1;
    fix_valid = 1'b1;
    fix_PC = 32'd7;
    fix_result = 1'b1;
    fix_target = 32'd77;
    step();
    lookup_valid = 1'b0;
    fix_valid = 1'b0;
    exp = {1'b1, 1'b0, 32'd8};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL simul_old_state actual=%h required=%h", obs, exp);
    else passed++;
    // GHR=1 now: PC 6 indexes counter 7, which was just trained.
    do_lookup(32'd6);
    exp = {1'b1, 1'b1, 32'd7};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL simul_new_state actual=%h required=%h", obs, exp);
    else passed++;
    PC = 32'd6;
    lookup_valid = 1'b1;
    fix_valid = 1'b1;
    fix_PC = 32'd6;
    fix_result = 1'b1;
    fix_target = 32'd99;
    step();
    lookup_valid = 1'b0;
    fix_valid = 1'b0;
    exp = {1'b1, 1'b1, 32'd7};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL simul_btb_no_bypass actual=%h required=%h", obs, exp);
    else passed++;
    // GHR=3: PC 4 indexes counter 7 again.
    do_lookup(32'd4);
    exp = {1'b1, 1'b1, 32'd5};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL simul_after actual=%h required=%h", obs, exp);
    else passed++;
  endtask

  task automatic test_btb();
    apply_reset();
    do_fix(32'd2, 1'b1, 32'd100);
    for (int k = 0; k < 8; k++) do_fix(32'd200, 1'b0, 32'd0);
    do_fix(32'd18, 1'b1, 32'd200);
    for (int k = 0; k < 8; k++) do_fix(32'd200, 1'b0, 32'd0);
    do_lookup(32'd2);
    exp = {1'b1, 1'b1, 32'd3};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL btb_tag_miss actual=%h required=%h", obs, exp);
    else passed++;
    do_lookup(32'd18);
    exp = {1'b1, 1'b1, 32'd200};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL btb_hit actual=%h required=%h", obs, exp);
    else passed++;
    do_fix(32'd34, 1'b0, 32'd300);
    do_lookup(32'd18);
    exp = {1'b1, 1'b1, 32'd200};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL btb_nt_untouched actual=%h required=%h", obs, exp);
    else passed++;
    do_lookup(32'hFFFFFFFF);
    exp = {1'b1, 1'b0, 32'd0};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL btb_wrap actual=%h required=%h", obs, exp);
    else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_fix(32'd5, 1'b1, 32'd55);
    do_lookup(32'd4);
    exp = {1'b1, 1'b1, 32'd5};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL mid_trained actual=%h required=%h", obs, exp);
    else passed++;
    PC = 32'd4;
    lookup_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    exp = {1'b0, 1'b0, 32'd0};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL mid_async_clear actual=%h required=%h", obs, exp);
    else passed++;
    step();
    reset = 1'b1;
    lookup_valid = 1'b0;
    step();
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL mid_discarded actual=%h required=%h", obs, exp);
    else passed++;
    do_lookup(32'd5);
    exp = {1'b1, 1'b0, 32'd6};
    obs = {pred_valid, prediction_gh, gh_PC};
    checks++;
    if (obs !== exp) $display("FAIL mid_tables_cleared actual=%h required=%h", obs, exp);
    else passed++;
  endtask

  initial begin
    passed = 0;
    checks = 0;
    reset = 1'b0;
    PC = 32'd0;
    lookup_valid = 1'b0;
    fix_valid = 1'b0;
    fix_PC = 32'd0;
    fix_result = 1'b0;
    fix_target = 32'd0;
    #1;
    test_reset();
    test_saturation();
    test_aliasing();
    test_simultaneous();
    test_btb();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
